// File: rtl/vgroup_wb_collector_pkg.sv
// Shared vector-unit definitions: LMUL encodings, LMUL decode and the
// writeback collector FSM state type.
package vgroup_wb_collector_pkg;

    localparam logic [2:0] LMUL_1 = 3'b000;
    localparam logic [2:0] LMUL_2 = 3'b001;
    localparam logic [2:0] LMUL_4 = 3'b010;
    localparam logic [2:0] LMUL_8 = 3'b011;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    // Group size in registers; reserved encodings (1xx) collapse to one register.
    function automatic logic [3:0] lmul_decode(input logic [2:0] code);
        case (code)
            LMUL_1:  return 4'd1;
            LMUL_2:  return 4'd2;
            LMUL_4:  return 4'd4;
            LMUL_8:  return 4'd8;
            default: return 4'd1;
        endcase
    endfunction

    function automatic logic lmul_invalid(input logic [2:0] code);
        return code[2];
    endfunction

endpackage

// File: rtl/vgroup_busy_mask.sv
// Per-register pending mask for one register group; member indices wrap
// modulo NREG (NREG must equal 2**AW).
module vgroup_busy_mask #(
    parameter int NREG = 32,
    parameter int AW   = 5
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            i_set,
    input  logic [AW-1:0]   i_base,
    input  logic [3:0]      i_n,
    input  logic            i_clr,
    input  logic [AW-1:0]   i_clr_idx,
    input  logic            i_clr_all,
    output logic [NREG-1:0] o_mask
);

    logic [NREG-1:0] r_mask;
    logic [NREG-1:0] w_set_mask;

    // AW-bit addition gives the mod-NREG wrap for groups crossing the top register.
    always_comb begin
        w_set_mask = '0;
        for (int k = 0; k < 8; k++) begin
            if (k < int'(i_n)) begin
                w_set_mask[i_base + AW'(k)] = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset || i_clr_all) begin
            r_mask <= '0;
        end else if (i_set) begin
            r_mask <= w_set_mask;
        end else if (i_clr) begin
            r_mask[i_clr_idx] <= 1'b0;
        end
    end

    assign o_mask = r_mask;

endmodule

// File: rtl/vgroup_wb_collector.sv
// Sequences the per-member result beats of an LMUL register group into the
// vector register file and tracks which group members are still unwritten.
module vgroup_wb_collector
    import vgroup_wb_collector_pkg::*;
#(
    parameter int VLEN = 128,
    parameter int NREG = 32,
    parameter int AW   = 5
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            grp_start,
    input  logic [AW-1:0]   grp_base,
    input  logic [2:0]      grp_lmul,
    output logic            grp_ready,
    input  logic            res_valid,
    input  logic [2:0]      res_idx,
    input  logic [VLEN-1:0] res_data,
    output logic            res_ready,
    input  logic            flush,
    output logic            vrf_we,
    output logic [AW-1:0]   vrf_waddr,
    output logic [VLEN-1:0] vrf_wdata,
    output logic [NREG-1:0] busy_mask,
    output logic            grp_done,
    output logic            seq_err,
    output logic            lmul_err,
    output logic [1:0]      dbg_state
);

    // Handshakes: a group is taken when grp_start & grp_ready, a beat when
    // res_valid & res_ready; flush overrides both in the same cycle.

    state_t          r_state;
    state_t          w_next_state;
    logic [2:0]      r_cnt;
    logic [AW-1:0]   r_base;
    logic [3:0]      r_n;
    logic            r_we;
    logic [AW-1:0]   r_waddr;
    logic [VLEN-1:0] r_wdata;
    logic            r_done;
    logic            r_seq_err;
    logic            r_lmul_err;

    logic            w_grp_ready;
    logic            w_res_ready;
    logic            w_take_grp;
    logic            w_beat_hit;
    logic            w_beat_miss;
    logic            w_last;
    logic [AW-1:0]   w_cur_addr;

    assign w_cur_addr = r_base + AW'(r_cnt);

    always_comb begin
        w_next_state = r_state;
        w_grp_ready  = 1'b0;
        w_res_ready  = 1'b0;
        w_take_grp   = 1'b0;
        w_beat_hit   = 1'b0;
        w_beat_miss  = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                w_grp_ready = 1'b1;
                if (grp_start) begin
                    w_take_grp   = 1'b1;
                    w_next_state = ST_COLLECT;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_COLLECT: begin
                w_res_ready = 1'b1;
                if (res_valid) begin
                    if (res_idx == r_cnt) begin
                        w_beat_hit = 1'b1;
                        if (r_cnt == 3'(r_n - 4'd1)) begin
                            w_last       = 1'b1;
                            w_next_state = ST_DONE;
                        end
                    end else begin
                        w_beat_miss = 1'b1;
                    end
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
        if (flush) begin
            w_next_state = ST_IDLE;
            w_take_grp   = 1'b0;
            w_beat_hit   = 1'b0;
            w_beat_miss  = 1'b0;
            w_last       = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_base     <= '0;
            r_n        <= 4'd1;
            r_we       <= 1'b0;
            r_waddr    <= '0;
            r_wdata    <= '0;
            r_done     <= 1'b0;
            r_seq_err  <= 1'b0;
            r_lmul_err <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_we       <= w_beat_hit;
            r_done     <= w_beat_hit && w_last;
            r_seq_err  <= w_beat_miss;
            r_lmul_err <= w_take_grp && lmul_invalid(grp_lmul);
            if (w_take_grp) begin
                r_base <= grp_base;
                r_n    <= lmul_decode(grp_lmul);
                r_cnt  <= '0;
            end
            if (w_beat_hit) begin
                r_waddr <= w_cur_addr;
                r_wdata <= res_data;
                r_cnt   <= r_cnt + 3'd1;
            end
            if (flush) begin
                r_cnt <= '0;
            end
        end
    end

    vgroup_busy_mask #(
        .NREG(NREG),
        .AW  (AW)
    ) u_busy (
        .clock    (clock),
        .reset    (reset),
        .i_set    (w_take_grp),
        .i_base   (grp_base),
        .i_n      (lmul_decode(grp_lmul)),
        .i_clr    (w_beat_hit),
        .i_clr_idx(w_cur_addr),
        .i_clr_all(flush || (w_beat_hit && w_last)),
        .o_mask   (busy_mask)
    );

    assign grp_ready = w_grp_ready;
    assign res_ready = w_res_ready;
    assign vrf_we    = r_we;
    assign vrf_waddr = r_waddr;
    assign vrf_wdata = r_wdata;
    assign grp_done  = r_done;
    assign seq_err   = r_seq_err;
    assign lmul_err  = r_lmul_err;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_vgroup_wb_collector.sv
// Directed bench for vgroup_wb_collector: group sequencing, wrap, index
// mismatch, flush, back-to-back groups and reserved LMUL encodings.
module tb_vgroup_wb_collector;

    localparam int VLEN = 128;
    localparam int NREG = 32;
    localparam int AW   = 5;

    logic            clock;
    logic            reset;
    logic            grp_start;
    logic [AW-1:0]   grp_base;
    logic [2:0]      grp_lmul;
    logic            grp_ready;
    logic            res_valid;
    logic [2:0]      res_idx;
    logic [VLEN-1:0] res_data;
    logic            res_ready;
    logic            flush;
    logic            vrf_we;
    logic [AW-1:0]   vrf_waddr;
    logic [VLEN-1:0] vrf_wdata;
    logic [NREG-1:0] busy_mask;
    logic            grp_done;
    logic            seq_err;
    logic            lmul_err;
    logic [1:0]      dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    vgroup_wb_collector #(
        .VLEN(VLEN),
        .NREG(NREG),
        .AW  (AW)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .grp_start(grp_start),
        .grp_base (grp_base),
        .grp_lmul (grp_lmul),
        .grp_ready(grp_ready),
        .res_valid(res_valid),
        .res_idx  (res_idx),
        .res_data (res_data),
        .res_ready(res_ready),
        .flush    (flush),
        .vrf_we   (vrf_we),
        .vrf_waddr(vrf_waddr),
        .vrf_wdata(vrf_wdata),
        .busy_mask(busy_mask),
        .grp_done (grp_done),
        .seq_err  (seq_err),
        .lmul_err (lmul_err),
        .dbg_state(dbg_state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_grp(input logic [AW-1:0] base, input logic [2:0] lmul);
        grp_start = 1'b1;
        grp_base  = base;
        grp_lmul  = lmul;
        step();
        grp_start = 1'b0;
    endtask

    task automatic beat(input logic [2:0] idx, input logic [VLEN-1:0] data);
        res_valid = 1'b1;
        res_idx   = idx;
        res_data  = data;
        step();
        res_valid = 1'b0;
    endtask

    // Checks the cycle after an accepted in-order beat.
    task automatic chk_write(input string tag, input logic [AW-1:0] addr, input logic [VLEN-1:0] data,
                             input logic [NREG-1:0] mask, input logic done);
        chk({tag, "_we"}, vrf_we, 1'b1);
        chk({tag, "_addr"}, vrf_waddr, addr);
        chk({tag, "_data"}, vrf_wdata, data);
        chk({tag, "_busy"}, busy_mask, mask);
        chk({tag, "_done"}, grp_done, done);
    endtask

    initial begin
        reset     = 1'b1;
        grp_start = 1'b0;
        grp_base  = '0;
        grp_lmul  = 3'b000;
        res_valid = 1'b0;
        res_idx   = '0;
        res_data  = '0;
        flush     = 1'b0;
        step();
        step();
        chk("rst_grp_ready", grp_ready, 1'b1);
        chk("rst_res_ready", res_ready, 1'b0);
        chk("rst_we", vrf_we, 1'b0);
        chk("rst_waddr", vrf_waddr, 5'd0);
        chk("rst_wdata", vrf_wdata, 128'd0);
        chk("rst_busy", busy_mask, 32'd0);
        chk("rst_pulses", {grp_done, seq_err, lmul_err}, 3'b000);
        chk("rst_state", dbg_state, 2'd0);
        reset = 1'b0;
        step();

        // Group base=4, LMUL=4; a grp_start during COLLECT must be ignored.
        start_grp(5'd4, 3'b010);
        chk("g1_busy0", busy_mask, 32'h0000_00F0);
        chk("g1_ready", {grp_ready, res_ready}, 2'b01);
        chk("g1_lmul_err", lmul_err, 1'b0);
        grp_start = 1'b1;
        grp_base  = 5'd20;
        grp_lmul  = 3'b011;
        beat(3'd0, 128'hA0);
        grp_start = 1'b0;
        chk_write("g1_b0", 5'd4, 128'hA0, 32'h0000_00E0, 1'b0);
        beat(3'd1, 128'hA1);
        chk_write("g1_b1", 5'd5, 128'hA1, 32'h0000_00C0, 1'b0);
        beat(3'd2, 128'hA2);
        chk_write("g1_b2", 5'd6, 128'hA2, 32'h0000_0080, 1'b0);
        beat(3'd3, 128'hDEAD_BEEF_0000_0000_1234_5678_9ABC_DEF0);
        chk_write("g1_b3", 5'd7, 128'hDEAD_BEEF_0000_0000_1234_5678_9ABC_DEF0, 32'h0, 1'b1);
        chk("g1_done_ready", grp_ready, 1'b1);
        step();
        chk("g1_idle_we", vrf_we, 1'b0);
        chk("g1_idle_done", grp_done, 1'b0);
        chk("g1_idle_state", dbg_state, 2'd0);

        // Group base=30, LMUL=4 wraps past register 31.
        start_grp(5'd30, 3'b010);
        chk("g2_busy0", busy_mask, 32'hC000_0003);
        beat(3'd0, 128'hB0);
        chk_write("g2_b0", 5'd30, 128'hB0, 32'h8000_0003, 1'b0);
        beat(3'd1, 128'hB1);
        chk_write("g2_b1", 5'd31, 128'hB1, 32'h0000_0003, 1'b0);
        beat(3'd2, 128'hB2);
        chk_write("g2_b2", 5'd0, 128'hB2, 32'h0000_0002, 1'b0);
        beat(3'd3, 128'hB3);
        chk_write("g2_b3", 5'd1, 128'hB3, 32'h0, 1'b1);
        step();

        // Group base=8, LMUL=2 with a repeated index 0.
        start_grp(5'd8, 3'b001);
        chk("g3_busy0", busy_mask, 32'h0000_0300);
        beat(3'd0, 128'hC0);
        chk_write("g3_b0", 5'd8, 128'hC0, 32'h0000_0200, 1'b0);
        chk("g3_b0_seq", seq_err, 1'b0);
        beat(3'd0, 128'hCC);
        chk("g3_bad_we", vrf_we, 1'b0);
        chk("g3_bad_seq", seq_err, 1'b1);
        chk("g3_bad_busy", busy_mask, 32'h0000_0200);
        chk("g3_bad_done", grp_done, 1'b0);
        beat(3'd1, 128'hC1);
        chk_write("g3_b1", 5'd9, 128'hC1, 32'h0, 1'b1);
        chk("g3_b1_seq", seq_err, 1'b0);
        step();
        chk("g3_done_once", grp_done, 1'b0);

        // Group base=2, LMUL=8 flushed after three beats; the flush-cycle beat is dropped.
        start_grp(5'd2, 3'b011);
        chk("g4_busy0", busy_mask, 32'h0000_03FC);
        beat(3'd0, 128'hD0);
        chk_write("g4_b0", 5'd2, 128'hD0, 32'h0000_03F8, 1'b0);
        beat(3'd1, 128'hD1);
        chk_write("g4_b1", 5'd3, 128'hD1, 32'h0000_03F0, 1'b0);
        beat(3'd2, 128'hD2);
        chk_write("g4_b2", 5'd4, 128'hD2, 32'h0000_03E0, 1'b0);
        flush = 1'b1;
        beat(3'd3, 128'hD3);
        flush = 1'b0;
        chk("g4_fl_we", vrf_we, 1'b0);
        chk("g4_fl_busy", busy_mask, 32'h0);
        chk("g4_fl_done", grp_done, 1'b0);
        chk("g4_fl_ready", {grp_ready, res_ready}, 2'b10);
        step();
        chk("g4_after_done", grp_done, 1'b0);

        // Group A (base=0, LMUL=1) then B (base=16, LMUL=2) started in A's DONE cycle.
        start_grp(5'd0, 3'b000);
        chk("g5a_busy0", busy_mask, 32'h0000_0001);
        beat(3'd0, 128'hE0);
        chk_write("g5a_b0", 5'd0, 128'hE0, 32'h0, 1'b1);
        chk("g5a_state", dbg_state, 2'd2);
        start_grp(5'd16, 3'b001);
        chk("g5b_state", dbg_state, 2'd1);
        chk("g5b_busy0", busy_mask, 32'h0003_0000);
        chk("g5b_done", grp_done, 1'b0);
        beat(3'd0, 128'hF0);
        chk_write("g5b_b0", 5'd16, 128'hF0, 32'h0002_0000, 1'b0);
        beat(3'd1, 128'hF1);
        chk_write("g5b_b1", 5'd17, 128'hF1, 32'h0, 1'b1);
        step();

        // Reserved LMUL encoding 101 behaves as one register and flags lmul_err once.
        start_grp(5'd5, 3'b101);
        chk("g6_lmul_err", lmul_err, 1'b1);
        chk("g6_busy0", busy_mask, 32'h0000_0020);
        step();
        chk("g6_lmul_err_off", lmul_err, 1'b0);
        chk("g6_hold_we", vrf_we, 1'b0);
        chk("g6_hold_busy", busy_mask, 32'h0000_0020);
        beat(3'd0, 128'h55);
        chk_write("g6_b0", 5'd5, 128'h55, 32'h0, 1'b1);
        step();
        chk("g6_idle_state", dbg_state, 2'd0);

        // Reset mid-group cancels the pending write.
        start_grp(5'd12, 3'b010);
        res_valid = 1'b1;
        res_idx   = 3'd0;
        res_data  = 128'h77;
        step();
        res_valid = 1'b0;
        reset     = 1'b1;
        step();
        reset = 1'b0;
        chk("rst2_we", vrf_we, 1'b0);
        chk("rst2_busy", busy_mask, 32'h0);
        chk("rst2_state", dbg_state, 2'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/vgroup_wb_collector.md
Name: vgroup_wb_collector

Overview:
- Writeback-side counterpart of the LMUL grouping selector in the vector unit.
- Decode/issue announces a register group: base vd plus encoded LMUL. The ALU pipeline then returns one result per member register. The block sequences those results into the vector register file at vd, vd+1, …, vd+LMUL-1.
- Tracks which registers of the group are still pending, exposes a per-register busy mask for hazard checks, and pulses completion when the whole group has been written.

Parameters:
- VLEN, 128, width of one vector register / one result beat in bits
- NREG, 32, number of architectural vector registers
- AW, 5, register address width (log2 NREG)

Ports:
- clock  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- grp_start  in  1  new group announced (sampled only when grp_ready=1)
- grp_base  in  AW  base destination register vd
- grp_lmul  in  3  encoded LMUL: 000=1, 001=2, 010=4, 011=8
- grp_ready  out  1  collector can accept a new group
- res_valid  in  1  result beat valid
- res_idx  in  3  member index of the beat (0..LMUL-1)
- res_data  in  VLEN  result data
- res_ready  out  1  collector accepts a beat this cycle
- flush  in  1  abort the current group (branch/trap kill)
- vrf_we  out  1  register file write enable
- vrf_waddr  out  AW  register file write address
- vrf_wdata  out  VLEN  register file write data
- busy_mask  out  NREG  bit r=1 while register r is an unwritten member of the active group
- grp_done  out  1  one-cycle pulse: group fully written
- seq_err  out  1  one-cycle pulse: beat rejected (index mismatch)
- lmul_err  out  1  one-cycle pulse: start with encoding 1xx

Behaviour:
- Reset: state=IDLE. Outputs: grp_ready=1, res_ready=0, vrf_we=0, vrf_waddr=0, vrf_wdata=0, busy_mask=0, grp_done=0, seq_err=0, lmul_err=0. Internal: cnt=0, base=0, n=1.
- FSM states: IDLE, COLLECT, DONE.
- IDLE: grp_ready=1, res_ready=0.
  - On grp_start, latch base and n = decoded LMUL (1/2/4/8). Set busy_mask bits base..base+n-1, indices mod NREG. Set cnt=0 and go to COLLECT.
  - Encoding 1xx: treat as n=1 and pulse lmul_err in the next cycle.
- COLLECT: grp_ready=0, res_ready=1. A beat is accepted when res_valid & res_ready.
  - res_idx==cnt: register the write. Next cycle vrf_we=1, vrf_waddr=(base+cnt) mod NREG (5-bit wrap), vrf_wdata=res_data. Clear that register's busy_mask bit in the same edge. Increment cnt.
  - Accepted beat with cnt==n-1: go to DONE.
  - res_idx!=cnt: no write, cnt unchanged, seq_err pulses the next cycle, beat consumed.
  - res_valid low: hold state; vrf_we=0.
- DONE (1 cycle): grp_done=1, busy_mask=0, grp_ready=1, res_ready=0.
  - grp_start in DONE is accepted exactly as in IDLE, so back-to-back groups run with no bubble. Otherwise go to IDLE.
- Write latency: 1 cycle from beat acceptance to vrf_we. At most one write per cycle.
- flush: takes priority over every other input in any state.
  - Next state IDLE, busy_mask=0, cnt=0.
  - No grp_done; any beat presented that cycle is dropped.
  - A write already registered from the previous cycle still completes.
- reset mid-group: same as flush, plus the pending write is cancelled (vrf_we=0).
- grp_start while in COLLECT: ignored (grp_ready=0); the issuer must hold it.
- All pulse outputs (grp_done, seq_err, lmul_err) are registered and last exactly one cycle.

Decomposition:
- Shared vector package holds:
  - LMUL encoding constants (LMUL_1..LMUL_8)
  - the LMUL decode function (3-bit code to group size, invalid mapped to 1), shared with the grouping selector
  - the FSM state enum
- Natural sub-module: vgroup_busy_mask. Inputs: base, n, set, clear-index, clear-all. Output: NREG-bit mask with mod-NREG wrap handling.

Test Plan:
- Base=4, lmul=010, beats idx 0..3 on consecutive cycles -> vrf_we on 4 cycles to addrs 4,5,6,7. busy_mask 0x00F0 shrinks to 0. grp_done one cycle after the last write edge.
- Base=30, lmul=010 -> initial busy_mask bits 30,31,0,1 (0xC0000003). Writes to 30,31,0,1.
- Base=8, lmul=001, beats idx 0 then idx 0 again then idx 1 -> second beat gives seq_err pulse and no write. Writes only to 8 and 9. grp_done once.
- Base=2, lmul=011, flush after 3 accepted beats -> writes 2,3,4 only, busy_mask=0, no grp_done, grp_ready=1 the next cycle.
- Group A (base=0, lmul=000) with grp_start for group B (base=16, lmul=001) asserted in A's DONE cycle -> B accepted with no idle cycle. Writes 0, then 16,17.
- Start with lmul=101 -> lmul_err pulse. Behaves as LMUL=1: single write to base, then grp_done.
